// File: rtl/cdb_writeback.sv
// rtl/cdb_writeback.sv - CDB arbitration, result broadcast and register/status writeback; optional CDB_PERF_EN counters
module cdb_writeback #(
    parameter int WORD_SIZE = 32,
    parameter int REG_INDEX = 5,
    parameter int FU_INDEX  = 3,
    parameter int NUM_FU    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_FU-1:0]             fu_valid,
    input  logic [NUM_FU*REG_INDEX-1:0]   fu_dest,
    input  logic [NUM_FU*WORD_SIZE-1:0]   fu_data,
    output logic [NUM_FU-1:0]             fu_ack,
    output logic                          cdb_valid,
    output logic [FU_INDEX-1:0]           cdb_tag,
    output logic [WORD_SIZE-1:0]          cdb_data,
    output logic [REG_INDEX-1:0]          lookup_num,
    input  logic [FU_INDEX-1:0]           lookup_status,
    input  logic [REG_INDEX-1:0]          issue_rs_src,
    input  logic [FU_INDEX-1:0]           issue_rs_status,
    input  logic                          issue_rs_enable,
    output logic [REG_INDEX-1:0]          write_reg_src,
    output logic [WORD_SIZE-1:0]          write_reg_data,
    output logic                          write_reg_enable,
    output logic [REG_INDEX-1:0]          write_rs_src,
    output logic [FU_INDEX-1:0]           write_rs_status,
    output logic                          write_rs_enable
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]                   perf_bcast_count,
    output logic [31:0]                   perf_stall_count
`endif
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [PTR_W:0]       NUM_FU_W  = (PTR_W + 1)'(NUM_FU);
    localparam logic [PTR_W-1:0]     LAST_IDX  = PTR_W'(NUM_FU - 1);
    localparam logic [FU_INDEX-1:0]  TAG_READY = '0;

    logic                 s1_valid_q, s1_valid_d;
    logic [FU_INDEX-1:0]  s1_tag_q,   s1_tag_d;
    logic [REG_INDEX-1:0] s1_dest_q,  s1_dest_d;
    logic [WORD_SIZE-1:0] s1_data_q,  s1_data_d;
    logic [PTR_W-1:0]     rr_ptr_q,   rr_ptr_d;

    logic                 match;
    logic                 stall;
    logic                 grant_any;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W:0]       arb_sum;
    logic [FU_INDEX-1:0]  sel_tag;
    logic [REG_INDEX-1:0] sel_dest;
    logic [WORD_SIZE-1:0] sel_data;

    // Broadcast side: a result only writes back if its producer still owns the register.
    always_comb begin
        match = s1_valid_q && (lookup_status == s1_tag_q);
        stall = match && issue_rs_enable && (issue_rs_src != s1_dest_q);
    end

    // Round-robin pick of the first pending FU at or after the pointer; blocked while stage 1 holds.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        arb_sum   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            arb_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (arb_sum >= NUM_FU_W) begin
                arb_sum = arb_sum - NUM_FU_W;
            end
            if (!grant_any && fu_valid[arb_sum[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = arb_sum[PTR_W-1:0];
            end
        end
        if (stall || reset) begin
            grant_any = 1'b0;
        end
    end

    // Select the granted FU's operands and form the one-hot ack.
    always_comb begin
        fu_ack   = '0;
        sel_tag  = TAG_READY;
        sel_dest = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_tag  = FU_INDEX'(i + 1);
                sel_dest = fu_dest[i*REG_INDEX +: REG_INDEX];
                sel_data = fu_data[i*WORD_SIZE +: WORD_SIZE];
                fu_ack[i] = grant_any;
            end
        end
    end

    // Stage-1 load on grant, drain on retire, hold on stall; pointer advances past the winner.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tag_d   = s1_tag_q;
        s1_dest_d  = s1_dest_q;
        s1_data_d  = s1_data_q;
        rr_ptr_d   = rr_ptr_q;
        if (grant_any) begin
            s1_valid_d = 1'b1;
            s1_tag_d   = sel_tag;
            s1_dest_d  = sel_dest;
            s1_data_d  = sel_data;
            rr_ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
        end else if (!stall) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage-1 register and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s1_dest_q  <= '0;
            s1_data_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s1_dest_q  <= s1_dest_d;
            s1_data_q  <= s1_data_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // CDB, register-file write and the shared status port (issue writes beat clears).
    always_comb begin
        cdb_valid        = s1_valid_q;
        cdb_tag          = s1_tag_q;
        cdb_data         = s1_data_q;
        lookup_num       = s1_dest_q;
        write_reg_src    = s1_dest_q;
        write_reg_data   = s1_data_q;
        write_reg_enable = match && !stall;
        write_rs_src     = '0;
        write_rs_status  = TAG_READY;
        write_rs_enable  = 1'b0;
        if (reset) begin
            write_rs_enable = 1'b0;
        end else if (issue_rs_enable) begin
            write_rs_src    = issue_rs_src;
            write_rs_status = issue_rs_status;
            write_rs_enable = 1'b1;
        end else if (match) begin
            write_rs_src    = s1_dest_q;
            write_rs_status = TAG_READY;
            write_rs_enable = 1'b1;
        end
    end

`ifdef CDB_PERF_EN
    logic [31:0] bcast_cnt_q, bcast_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count retired broadcasts and stall cycles; both wrap naturally.
    always_comb begin
        bcast_cnt_d = bcast_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (s1_valid_q && !stall) begin
            bcast_cnt_d = bcast_cnt_q + 32'd1;
        end
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcast_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            bcast_cnt_q <= bcast_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_bcast_count = bcast_cnt_q;
    assign perf_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_writeback.sv
// tb/tb_cdb_writeback.sv - self-checking bench for cdb_writeback against a behavioural model
module tb_cdb_writeback;

    localparam int NUM_FU = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  fu_valid;
    logic [19:0] fu_dest;
    logic [127:0] fu_data;
    logic [3:0]  fu_ack;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [4:0]  lookup_num;
    logic [2:0]  lookup_status;
    logic [4:0]  issue_rs_src;
    logic [2:0]  issue_rs_status;
    logic        issue_rs_enable;
    logic [4:0]  write_reg_src;
    logic [31:0] write_reg_data;
    logic        write_reg_enable;
    logic [4:0]  write_rs_src;
    logic [2:0]  write_rs_status;
    logic        write_rs_enable;
`ifdef CDB_PERF_EN
    logic [31:0] perf_bcast_count;
    logic [31:0] perf_stall_count;
`endif

    cdb_writeback dut (
        .clk              (clk),
        .reset            (reset),
        .fu_valid         (fu_valid),
        .fu_dest          (fu_dest),
        .fu_data          (fu_data),
        .fu_ack           (fu_ack),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .lookup_num       (lookup_num),
        .lookup_status    (lookup_status),
        .issue_rs_src     (issue_rs_src),
        .issue_rs_status  (issue_rs_status),
        .issue_rs_enable  (issue_rs_enable),
        .write_reg_src    (write_reg_src),
        .write_reg_data   (write_reg_data),
        .write_reg_enable (write_reg_enable),
        .write_rs_src     (write_rs_src),
        .write_rs_status  (write_rs_status),
        .write_rs_enable  (write_rs_enable)
`ifdef CDB_PERF_EN
        ,
        .perf_bcast_count (perf_bcast_count),
        .perf_stall_count (perf_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: the one result sitting on the bus plus the fairness pointer.
    bit          m_valid, n_valid;
    logic [2:0]  m_tag,   n_tag;
    logic [4:0]  m_dest,  n_dest;
    logic [31:0] m_data,  n_data;
    int          m_ptr,   n_ptr;
    int          last_grant;
    int unsigned e_bcast, e_stall, n_bcast, n_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fu(input int i, input bit v, input logic [4:0] d, input logic [31:0] x);
        fu_valid[i]        = v;
        fu_dest[i*5 +: 5]  = d;
        fu_data[i*32 +: 32] = x;
    endtask

    // Compare every output with what the model predicts for the current inputs, and plan the next state.
    task automatic eval_and_check();
        bit         mt, st, e_rs_en;
        int         g;
        logic [3:0] e_ack;
        logic [4:0] e_rs_src;
        logic [2:0] e_rs_st;
        if (reset) begin
            chk("rst_fu_ack", fu_ack, 0);
            chk("rst_cdb_valid", cdb_valid, 0);
            chk("rst_cdb_tag", cdb_tag, 0);
            chk("rst_cdb_data", cdb_data, 0);
            chk("rst_lookup_num", lookup_num, 0);
            chk("rst_wr_reg_en", write_reg_enable, 0);
            chk("rst_wr_reg_src", write_reg_src, 0);
            chk("rst_wr_reg_data", write_reg_data, 0);
            chk("rst_wr_rs_en", write_rs_enable, 0);
            chk("rst_wr_rs_src", write_rs_src, 0);
            chk("rst_wr_rs_status", write_rs_status, 0);
`ifdef CDB_PERF_EN
            chk("rst_perf_bcast", perf_bcast_count, 0);
            chk("rst_perf_stall", perf_stall_count, 0);
`endif
            n_valid = 0; n_tag = 0; n_dest = 0; n_data = 0; n_ptr = 0;
            n_bcast = 0; n_stall = 0;
            last_grant = -1;
            return;
        end
        mt = m_valid && (lookup_status == m_tag);
        st = mt && issue_rs_enable && (issue_rs_src != m_dest);
        g = -1;
        if (!st) begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (g < 0 && fu_valid[(m_ptr + k) % NUM_FU]) g = (m_ptr + k) % NUM_FU;
            end
        end
        e_ack = '0;
        if (g >= 0) e_ack[g] = 1'b1;
        chk("fu_ack", fu_ack, e_ack);
        chk("cdb_valid", cdb_valid, m_valid);
        if (m_valid) begin
            chk("cdb_tag", cdb_tag, m_tag);
            chk("cdb_data", cdb_data, m_data);
            chk("lookup_num", lookup_num, m_dest);
        end
        chk("wr_reg_en", write_reg_enable, mt && !st);
        if (mt && !st) begin
            chk("wr_reg_src", write_reg_src, m_dest);
            chk("wr_reg_data", write_reg_data, m_data);
        end
        if (issue_rs_enable) begin
            e_rs_en = 1; e_rs_src = issue_rs_src; e_rs_st = issue_rs_status;
        end else if (mt) begin
            e_rs_en = 1; e_rs_src = m_dest; e_rs_st = 3'd0;
        end else begin
            e_rs_en = 0; e_rs_src = 0; e_rs_st = 0;
        end
        chk("wr_rs_en", write_rs_enable, e_rs_en);
        if (e_rs_en) begin
            chk("wr_rs_src", write_rs_src, e_rs_src);
            chk("wr_rs_status", write_rs_status, e_rs_st);
        end
`ifdef CDB_PERF_EN
        chk("perf_bcast", perf_bcast_count, e_bcast);
        chk("perf_stall", perf_stall_count, e_stall);
`endif
        n_valid = m_valid; n_tag = m_tag; n_dest = m_dest; n_data = m_data; n_ptr = m_ptr;
        if (g >= 0) begin
            n_valid = 1;
            n_tag   = 3'(g + 1);
            n_dest  = fu_dest[g*5 +: 5];
            n_data  = fu_data[g*32 +: 32];
            n_ptr   = (g + 1) % NUM_FU;
        end else if (!st) begin
            n_valid = 0;
        end
        n_bcast = e_bcast + ((m_valid && !st) ? 1 : 0);
        n_stall = e_stall + (st ? 1 : 0);
        last_grant = g;
    endtask

    // Sample mid-cycle (inputs were driven just after the previous rising edge).
    task automatic settle();
        #4;
        eval_and_check();
    endtask

    task automatic advance();
        @(posedge clk);
        m_valid = n_valid; m_tag = n_tag; m_dest = n_dest; m_data = n_data; m_ptr = n_ptr;
        e_bcast = n_bcast; e_stall = n_stall;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        settle();
        advance();
        reset = 1'b0;
    endtask

    task automatic clear_inputs();
        fu_valid = '0; fu_dest = '0; fu_data = '0;
        lookup_status = '0; issue_rs_src = '0; issue_rs_status = '0; issue_rs_enable = 1'b0;
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        logic [31:0] a_data, b_data;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        m_valid = 0; m_tag = 0; m_dest = 0; m_data = 0; m_ptr = 0;
        e_bcast = 0; e_stall = 0; last_grant = -1;
        clear_inputs();
        do_reset();

        // Single result from FU2
        set_fu(2, 1, 5'd5, 32'hDEADBEEF);
        settle();
        chk("t1_ack", fu_ack, 4'b0100);
        advance();
        set_fu(2, 0, 5'd0, 32'h0);
        lookup_status = 3'd3;
        settle();
        chk("t1_cdb_valid", cdb_valid, 1);
        chk("t1_cdb_tag", cdb_tag, 3);
        chk("t1_wr_reg_en", write_reg_enable, 1);
        chk("t1_wr_reg_src", write_reg_src, 5);
        chk("t1_wr_reg_data", write_reg_data, 32'hDEADBEEF);
        chk("t1_wr_rs_en", write_rs_enable, 1);
        chk("t1_wr_rs_status", write_rs_status, 0);
        advance();
        lookup_status = 3'd0;
        settle();
        advance();

        // Round robin with all FUs busy, then a stale broadcast
        do_reset();
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 1, 5'(i + 1), $urandom);
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("rr_ack", fu_ack, rr_exp[c]);
            if (c > 0) chk("rr_cdb_valid", cdb_valid, 1);
            advance();
            for (int i = 0; i < NUM_FU; i++)
                if (last_grant == i) set_fu(i, 1, 5'($urandom_range(31)), $urandom);
        end
        lookup_status = 3'd2;
        settle();
        chk("stale_cdb_valid", cdb_valid, 1);
        chk("stale_cdb_tag", cdb_tag, 1);
        chk("stale_wr_reg_en", write_reg_enable, 0);
        chk("stale_wr_rs_en", write_rs_enable, 0);
        chk("stale_ack", fu_ack, 4'b0010);
        advance();
        fu_valid = '0;
        lookup_status = 3'd0;
        settle();
        advance();

        // Port conflict: issue to another register blocks the clear for 3 cycles
        do_reset();
        a_data = $urandom;
        b_data = $urandom;
        set_fu(0, 1, 5'd5, a_data);
        settle();
        advance();
        set_fu(0, 0, 5'd0, 32'h0);
        set_fu(1, 1, 5'd5, b_data);
        lookup_status = 3'd1;
        issue_rs_enable = 1'b1; issue_rs_src = 5'd7; issue_rs_status = 3'd2;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("conf_rs_en", write_rs_enable, 1);
            chk("conf_rs_src", write_rs_src, 7);
            chk("conf_rs_status", write_rs_status, 2);
            chk("conf_ack", fu_ack, 0);
            chk("conf_cdb_valid", cdb_valid, 1);
            chk("conf_wr_reg_en", write_reg_enable, 0);
            advance();
        end
        issue_rs_enable = 1'b0;
        settle();
        chk("conf4_wr_reg_en", write_reg_enable, 1);
        chk("conf4_wr_reg_src", write_reg_src, 5);
        chk("conf4_wr_reg_data", write_reg_data, a_data);
        chk("conf4_rs_en", write_rs_enable, 1);
        chk("conf4_rs_src", write_rs_src, 5);
        chk("conf4_rs_status", write_rs_status, 0);
        chk("conf4_ack", fu_ack, 4'b0010);
        advance();

        // Same-register issue: new producer wins the status port, data still written, no stall
        set_fu(1, 0, 5'd0, 32'h0);
        set_fu(3, 1, 5'd12, $urandom);
        lookup_status = 3'd2;
        issue_rs_enable = 1'b1; issue_rs_src = 5'd5; issue_rs_status = 3'd4;
        settle();
        chk("same_rs_src", write_rs_src, 5);
        chk("same_rs_status", write_rs_status, 4);
        chk("same_rs_en", write_rs_enable, 1);
        chk("same_wr_reg_en", write_reg_enable, 1);
        chk("same_wr_reg_data", write_reg_data, b_data);
        chk("same_ack", fu_ack, 4'b1000);
        advance();

        // Reset during a stall
        fu_valid = 4'b1111;
        lookup_status = 3'd4;
        issue_rs_src = 5'd7;
        settle();
        chk("rst_stall_ack", fu_ack, 0);
        advance();
        do_reset();
        issue_rs_enable = 1'b0;
        lookup_status = 3'd0;
        settle();
        chk("post_rst_ack", fu_ack, 4'b0001);
        advance();

        // Randomized traffic against the model
        clear_inputs();
        settle();
        advance();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && last_grant == i) begin
                    if ($urandom_range(9) < 6) set_fu(i, 1, 5'($urandom_range(31)), $urandom);
                    else set_fu(i, 0, 5'd0, 32'h0);
                end else if (!fu_valid[i] && $urandom_range(9) < 3) begin
                    set_fu(i, 1, 5'($urandom_range(31)), $urandom);
                end
            end
            lookup_status   = ($urandom_range(1) == 1) ? m_tag : 3'($urandom_range(7));
            issue_rs_enable = ($urandom_range(9) < 4);
            issue_rs_src    = ($urandom_range(2) == 0) ? m_dest : 5'($urandom_range(31));
            issue_rs_status = 3'($urandom_range(7));
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_writeback.md
Name: cdb_writeback

Overview:
- Result-writeback end of the register-status interface.
- Arbitrates finished functional-unit (FU) results onto a single common data bus (CDB).
- Broadcasts each granted result to the reservation stations.
- Drives the register file data write port and the register-status clear port.
- Owns the single status write port, so the issue stage's status writes are muxed through this block with priority over clears.

Parameters:
- WORD_SIZE, 32, data width.
- REG_INDEX, 5, register index width.
- FU_INDEX, 3, FU tag width; tag 0 = READY, tags 1..NUM_FU = FUs.
- NUM_FU, 4, number of requesting FUs; must be <= 2**FU_INDEX-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fu_valid  in  NUM_FU  result pending per FU; bit i = tag i+1.
- fu_dest  in  NUM_FU*REG_INDEX  destination register per FU; slice i.
- fu_data  in  NUM_FU*WORD_SIZE  result per FU; slice i.
- fu_ack  out  NUM_FU  one-hot one-cycle grant/accept pulse.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  FU_INDEX  producing FU tag.
- cdb_data  out  WORD_SIZE  broadcast result.
- lookup_num  out  REG_INDEX  equals cdb_dest; to the status read port.
- lookup_status  in  FU_INDEX  current status of lookup_num, combinational.
- issue_rs_src  in  REG_INDEX  issue-stage status write: register.
- issue_rs_status  in  FU_INDEX  issue-stage status write: new producer tag.
- issue_rs_enable  in  1  issue-stage status write: enable.
- write_reg_src  out  REG_INDEX  register file write: register.
- write_reg_data  out  WORD_SIZE  register file write: data.
- write_reg_enable  out  1  register file write: enable.
- write_rs_src  out  REG_INDEX  status write: register.
- write_rs_status  out  FU_INDEX  status write: value.
- write_rs_enable  out  1  status write: enable.

Behaviour:
- Reset: all outputs 0; round-robin pointer = 0; stage-1 register empty.
- Stage 0 (arbitration):
  - Round-robin over fu_valid, starting at the pointer.
  - Grant allowed only when stage 1 is empty or retiring this cycle.
  - Grant pulses fu_ack[i] for exactly one cycle and loads stage 1 at the clock edge with valid=1, tag=i+1, dest=fu_dest[i], data=fu_data[i].
  - Pointer moves to (i+1) mod NUM_FU.
  - An FU holds fu_valid and its operands until acked; it deasserts or presents a new result the cycle after the ack.
- Stage 1 (broadcast; cdb_* and lookup_num driven from the stage-1 register):
  - match = cdb_valid && (lookup_status == cdb_tag).
  - Retire condition: !issue_rs_enable || (issue_rs_src == cdb_dest) || !match.
  - Stall condition: issue_rs_enable && issue_rs_src != cdb_dest && match. Stage 1 holds, no grant issues, and cdb_valid stays high on repeated cycles; reservation stations tolerate the duplicate broadcast.
- Status port mux:
  - If issue_rs_enable: write_rs_* = issue_rs_*, regardless of the CDB.
  - Else if match: write_rs_src = cdb_dest, write_rs_status = READY (0), write_rs_enable = 1.
  - Else write_rs_enable = 0.
- Register file write:
  - write_reg_enable = match && !stall.
  - If the issue write targets cdb_dest in the same cycle, the clear is dropped (new producer wins) but the data write still occurs.
  - A stale result (no match) only broadcasts; it performs no register or status write.
- Latency: fu_valid high with stage 1 idle gives fu_ack in the same cycle and cdb_valid one cycle later.
- Throughput: one broadcast per cycle when no stalls.
- Reset mid-operation: the pending stage-1 result is discarded, and no ack is re-issued.

Optional Feature:
- Macro: CDB_PERF_EN.
- When defined, adds outputs perf_bcast_count (32 bits) and perf_stall_count (32 bits), both reset to 0.
  - perf_bcast_count increments each cycle stage 1 retires a valid entry.
  - perf_stall_count increments each stall cycle.
  - Both wrap at 2**32.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single result: FU2 (tag 3) presents dest=5, data=0xDEADBEEF, lookup_status=3 -> fu_ack=0100 in cycle 0; in cycle 1 cdb_valid=1, tag=3, write_reg_enable=1 (r5 <= 0xDEADBEEF), write_rs_enable=1 with status 0.
- Round robin: all four fu_valid held high -> acks in order 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no idle cycles on the CDB.
- Stale result: lookup_status=2, cdb_tag=1 -> cdb_valid=1, write_reg_enable=0, write_rs_enable=0, and a grant still proceeds.
- Port conflict: match on r5 while issue writes r7<=2 for 3 cycles -> status port carries issue writes, stage 1 held 3 cycles with no fu_ack, and r5 is written/cleared on cycle 4.
- Same-register issue: issue writes r5<=4 while the CDB writes r5 with match -> write_rs = (5,4), write_reg_enable=1, and no stall.
- Reset mid-stall: assert reset during a stall -> all outputs 0 immediately, and the following cycle's arbitration starts at FU0.
